// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and width defaults for the iCache/dCache memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam logic ARB_ID_I = 1'b0;
    localparam logic ARB_ID_D = 1'b1;

    localparam int MEM_ADDRESS_LEN   = 26;
    localparam int ICACHE_LINE_WIDTH = 128;
    localparam int STAT_CNT_W        = 16;

    // Round-robin winner for a two-way conflict: whoever did not win last time.
    function automatic logic rr_other(input logic last);
        rr_other = ~last;
    endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Combinational two-way round-robin picker; req[0] is the iCache, req[1] the dCache.
module mem_arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id,
    output logic       conflict
);

    // Pick the single requester, or alternate against the last winner on a tie.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = ARB_ID_I;
        conflict  = 1'b0;
        case (req)
            2'b01: begin
                gnt_valid = 1'b1;
                gnt_id    = ARB_ID_I;
            end
            2'b10: begin
                gnt_valid = 1'b1;
                gnt_id    = ARB_ID_D;
            end
            2'b11: begin
                gnt_valid = 1'b1;
                gnt_id    = rr_other(last);
                conflict  = 1'b1;
            end
            default: begin
                gnt_valid = 1'b0;
                gnt_id    = ARB_ID_I;
                conflict  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates iCache fills and dCache fills/write-backs onto one memory port,
// holding each transaction until acked and returning a one-cycle completion.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDRESS_LEN,
    parameter int LINE_W = ICACHE_LINE_WIDTH,
    parameter int CNT_W  = STAT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqI_mem,
    input  logic [ADDR_W-1:0] reqAddrI_mem,
    output logic [LINE_W-1:0] fillI_data,
    output logic              fillI_rdy,
    input  logic              reqD_mem,
    input  logic              reqD_we,
    input  logic [ADDR_W-1:0] reqAddrD_mem,
    input  logic [LINE_W-1:0] reqD_wdata,
    output logic [LINE_W-1:0] fillD_data,
    output logic              fillD_rdy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              grant_id,
    output logic [CNT_W-1:0]  stat_conflicts
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    arb_state_e        state_r, state_nxt_s;
    logic              mem_req_r, mem_req_nxt_s;
    logic              mem_we_r, mem_we_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt_s;
    logic [LINE_W-1:0] mem_wdata_r, mem_wdata_nxt_s;
    logic [LINE_W-1:0] fill_i_data_r, fill_i_data_nxt_s;
    logic [LINE_W-1:0] fill_d_data_r, fill_d_data_nxt_s;
    logic              fill_i_rdy_r, fill_i_rdy_nxt_s;
    logic              fill_d_rdy_r, fill_d_rdy_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              grant_id_r, grant_id_nxt_s;
    logic              last_grant_r, last_grant_nxt_s;
    logic [CNT_W-1:0]  conflicts_r, conflicts_nxt_s;
    logic              gnt_valid_s, gnt_id_s, conflict_s;

    mem_arb_rr2 u_rr2 (
        .req       ({reqD_mem, reqI_mem}),
        .last      (last_grant_r),
        .gnt_valid (gnt_valid_s),
        .gnt_id    (gnt_id_s),
        .conflict  (conflict_s)
    );

    // Next-state and next-output logic; requester inputs only matter in IDLE.
    always_comb begin
        state_nxt_s       = state_r;
        mem_req_nxt_s     = mem_req_r;
        mem_we_nxt_s      = mem_we_r;
        mem_addr_nxt_s    = mem_addr_r;
        mem_wdata_nxt_s   = mem_wdata_r;
        fill_i_data_nxt_s = fill_i_data_r;
        fill_d_data_nxt_s = fill_d_data_r;
        fill_i_rdy_nxt_s  = 1'b0;
        fill_d_rdy_nxt_s  = 1'b0;
        grant_id_nxt_s    = grant_id_r;
        last_grant_nxt_s  = last_grant_r;
        conflicts_nxt_s   = conflicts_r;
        case (state_r)
            ARB_IDLE: begin
                if (gnt_valid_s) begin
                    state_nxt_s      = ARB_BUSY;
                    mem_req_nxt_s    = 1'b1;
                    grant_id_nxt_s   = gnt_id_s;
                    last_grant_nxt_s = gnt_id_s;
                    if (gnt_id_s == ARB_ID_D) begin
                        mem_we_nxt_s    = reqD_we;
                        mem_addr_nxt_s  = reqAddrD_mem;
                        mem_wdata_nxt_s = reqD_wdata;
                    end else begin
                        mem_we_nxt_s    = 1'b0;
                        mem_addr_nxt_s  = reqAddrI_mem;
                        mem_wdata_nxt_s = '0;
                    end
                    if (conflict_s) begin
                        conflicts_nxt_s = sat_inc(conflicts_r);
                    end else begin
                        conflicts_nxt_s = conflicts_r;
                    end
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (mem_ack) begin
                    state_nxt_s   = ARB_RESP;
                    mem_req_nxt_s = 1'b0;
                    if (grant_id_r == ARB_ID_D) begin
                        fill_d_rdy_nxt_s = 1'b1;
                        if (!mem_we_r) begin
                            fill_d_data_nxt_s = mem_rdata;
                        end else begin
                            fill_d_data_nxt_s = fill_d_data_r;
                        end
                    end else begin
                        fill_i_rdy_nxt_s  = 1'b1;
                        fill_i_data_nxt_s = mem_rdata;
                    end
                end else begin
                    state_nxt_s = ARB_BUSY;
                end
            end
            ARB_RESP: begin
                state_nxt_s = ARB_IDLE;
            end
            default: begin
                state_nxt_s   = ARB_IDLE;
                mem_req_nxt_s = 1'b0;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ARB_IDLE);
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ARB_IDLE;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= '0;
            mem_wdata_r   <= '0;
            fill_i_data_r <= '0;
            fill_d_data_r <= '0;
            fill_i_rdy_r  <= 1'b0;
            fill_d_rdy_r  <= 1'b0;
            busy_r        <= 1'b0;
            grant_id_r    <= ARB_ID_I;
            last_grant_r  <= ARB_ID_D;
            conflicts_r   <= '0;
        end else begin
            state_r       <= state_nxt_s;
            mem_req_r     <= mem_req_nxt_s;
            mem_we_r      <= mem_we_nxt_s;
            mem_addr_r    <= mem_addr_nxt_s;
            mem_wdata_r   <= mem_wdata_nxt_s;
            fill_i_data_r <= fill_i_data_nxt_s;
            fill_d_data_r <= fill_d_data_nxt_s;
            fill_i_rdy_r  <= fill_i_rdy_nxt_s;
            fill_d_rdy_r  <= fill_d_rdy_nxt_s;
            busy_r        <= busy_nxt_s;
            grant_id_r    <= grant_id_nxt_s;
            last_grant_r  <= last_grant_nxt_s;
            conflicts_r   <= conflicts_nxt_s;
        end
    end

    assign mem_req        = mem_req_r;
    assign mem_we         = mem_we_r;
    assign mem_addr       = mem_addr_r;
    assign mem_wdata      = mem_wdata_r;
    assign fillI_data     = fill_i_data_r;
    assign fillD_data     = fill_d_data_r;
    assign fillI_rdy      = fill_i_rdy_r;
    assign fillD_rdy      = fill_d_rdy_r;
    assign busy           = busy_r;
    assign grant_id       = grant_id_r;
    assign stat_conflicts = conflicts_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; a second instance with a 2-bit counter shares
// the stimulus to exercise conflict-counter saturation.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         reqI_mem;
    logic [25:0]  reqAddrI_mem;
    logic [127:0] fillI_data;
    logic         fillI_rdy;
    logic         reqD_mem;
    logic         reqD_we;
    logic [25:0]  reqAddrD_mem;
    logic [127:0] reqD_wdata;
    logic [127:0] fillD_data;
    logic         fillD_rdy;
    logic         mem_req;
    logic         mem_we;
    logic [25:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ack;
    logic         busy;
    logic         grant_id;
    logic [15:0]  stat_conflicts;

    logic [127:0] s_fillI_data, s_fillD_data, s_mem_wdata;
    logic         s_fillI_rdy, s_fillD_rdy, s_mem_req, s_mem_we, s_busy, s_grant_id;
    logic [25:0]  s_mem_addr;
    logic [1:0]   s_stat;

    int errors = 0;
    int checks_total = 0;
    logic [127:0] exp_i = '0;
    logic [127:0] exp_d = '0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .reqI_mem(reqI_mem), .reqAddrI_mem(reqAddrI_mem),
        .fillI_data(fillI_data), .fillI_rdy(fillI_rdy),
        .reqD_mem(reqD_mem), .reqD_we(reqD_we), .reqAddrD_mem(reqAddrD_mem),
        .reqD_wdata(reqD_wdata), .fillD_data(fillD_data), .fillD_rdy(fillD_rdy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .grant_id(grant_id), .stat_conflicts(stat_conflicts)
    );

    mem_arbiter #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset),
        .reqI_mem(reqI_mem), .reqAddrI_mem(reqAddrI_mem),
        .fillI_data(s_fillI_data), .fillI_rdy(s_fillI_rdy),
        .reqD_mem(reqD_mem), .reqD_we(reqD_we), .reqAddrD_mem(reqAddrD_mem),
        .reqD_wdata(reqD_wdata), .fillD_data(s_fillD_data), .fillD_rdy(s_fillD_rdy),
        .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(s_busy), .grant_id(s_grant_id), .stat_conflicts(s_stat)
    );

    task automatic check_value(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks_total++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // One uncontended transaction; starts and ends at a negedge with the arbiter idle.
    task automatic single_txn(input logic is_d, input logic we, input logic [25:0] addr,
                              input logic [127:0] wdata, input logic [127:0] rdata, input int lat);
        logic we_eff;
        we_eff = is_d & we;
        if (is_d) begin
            reqD_mem = 1'b1; reqD_we = we; reqAddrD_mem = addr; reqD_wdata = wdata;
        end else begin
            reqI_mem = 1'b1; reqAddrI_mem = addr;
        end
        @(negedge clk);
        check_value("grant_id", grant_id, is_d);
        check_value("mem_req_grant", mem_req, 1'b1);
        check_value("mem_we", mem_we, we_eff);
        check_value("mem_addr", mem_addr, addr);
        check_value("busy_grant", busy, 1'b1);
        if (is_d) check_value("mem_wdata", mem_wdata, wdata);
        reqAddrI_mem = ~addr; reqAddrD_mem = ~addr; reqD_wdata = ~wdata; reqD_we = ~we;
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            check_value("mem_req_hold", mem_req, 1'b1);
            check_value("mem_addr_hold", mem_addr, addr);
            check_value("mem_we_hold", mem_we, we_eff);
            if (is_d) check_value("mem_wdata_hold", mem_wdata, wdata);
        end
        mem_rdata = rdata; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        if (!we_eff) begin
            if (is_d) exp_d = rdata;
            else exp_i = rdata;
        end
        check_value("mem_req_done", mem_req, 1'b0);
        check_value("fillI_rdy_pulse", fillI_rdy, !is_d);
        check_value("fillD_rdy_pulse", fillD_rdy, is_d);
        check_value("fillI_data", fillI_data, exp_i);
        check_value("fillD_data", fillD_data, exp_d);
        reqI_mem = 1'b0; reqD_mem = 1'b0; reqD_we = 1'b0;
        @(negedge clk);
        check_value("fillI_rdy_end", fillI_rdy, 1'b0);
        check_value("fillD_rdy_end", fillD_rdy, 1'b0);
        check_value("busy_end", busy, 1'b0);
    endtask

    // Both request together with last grant = D: I wins, then D is served alone.
    task automatic serve_pair(input int k);
        int exp_small;
        exp_small = (k > 3) ? 3 : k;
        reqI_mem = 1'b1; reqAddrI_mem = 26'h40 + k[25:0];
        reqD_mem = 1'b1; reqD_we = 1'b0; reqAddrD_mem = 26'h80 + k[25:0];
        @(negedge clk);
        check_value("pair_grant_i", grant_id, 1'b0);
        check_value("pair_addr_i", mem_addr, 26'h40 + k[25:0]);
        check_value("pair_stat", stat_conflicts, k);
        check_value("pair_stat_small", s_stat, exp_small);
        mem_rdata = {4{32'h1000_0000 + k}}; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        exp_i = {4{32'h1000_0000 + k}};
        check_value("pair_fillI_rdy", fillI_rdy, 1'b1);
        check_value("pair_fillD_rdy_low", fillD_rdy, 1'b0);
        check_value("pair_fillI_data", fillI_data, exp_i);
        reqI_mem = 1'b0;
        @(negedge clk);
        check_value("pair_gap_req", mem_req, 1'b0);
        check_value("pair_gap_busy", busy, 1'b0);
        @(negedge clk);
        check_value("pair_grant_d", grant_id, 1'b1);
        check_value("pair_addr_d", mem_addr, 26'h80 + k[25:0]);
        check_value("pair_stat_d", stat_conflicts, k);
        mem_rdata = {4{32'h2000_0000 + k}}; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        exp_d = {4{32'h2000_0000 + k}};
        check_value("pair_fillD_rdy", fillD_rdy, 1'b1);
        check_value("pair_fillD_data", fillD_data, exp_d);
        reqD_mem = 1'b0;
        @(negedge clk);
        check_value("pair_idle", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        reqI_mem = 1'b0; reqAddrI_mem = '0;
        reqD_mem = 1'b0; reqD_we = 1'b0; reqAddrD_mem = '0; reqD_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_value("rst_mem_req", mem_req, 1'b0);
        check_value("rst_busy", busy, 1'b0);
        check_value("rst_grant_id", grant_id, 1'b0);
        check_value("rst_stat", stat_conflicts, 16'd0);
        check_value("rst_fillI_data", fillI_data, 128'd0);
        check_value("rst_fillD_data", fillD_data, 128'd0);
        check_value("rst_mem_addr", mem_addr, 26'd0);

        single_txn(1'b0, 1'b0, 26'h000_0004, 128'd0, {16{8'hA5}}, 3);
        single_txn(1'b1, 1'b1, 26'h123, 128'h1, {4{32'hFFFF_0000}}, 2);

        for (int k = 1; k <= 5; k++) serve_pair(k);

        // Last grant = I, so a conflict now goes to D.
        single_txn(1'b0, 1'b0, 26'h7, 128'd0, {4{32'h7777_0000}}, 1);
        reqI_mem = 1'b1; reqAddrI_mem = 26'h9;
        reqD_mem = 1'b1; reqD_we = 1'b1; reqAddrD_mem = 26'hA; reqD_wdata = {4{32'hCAFE_F00D}};
        @(negedge clk);
        check_value("rr_grant_d", grant_id, 1'b1);
        check_value("rr_we", mem_we, 1'b1);
        check_value("rr_stat", stat_conflicts, 16'd6);
        check_value("rr_stat_small", s_stat, 2'd3);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check_value("rr_fillD_rdy", fillD_rdy, 1'b1);
        check_value("rr_fillD_keep", fillD_data, exp_d);
        reqD_mem = 1'b0; reqD_we = 1'b0;
        repeat (2) @(negedge clk);
        check_value("rr_grant_i", grant_id, 1'b0);
        mem_rdata = {4{32'h9999_0000}}; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        exp_i = {4{32'h9999_0000}};
        check_value("rr_fillI_data", fillI_data, exp_i);
        reqI_mem = 1'b0;
        @(negedge clk);

        // Spurious ack in IDLE.
        mem_rdata = {4{32'hDEAD_BEEF}}; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check_value("spur_fillI_rdy", fillI_rdy, 1'b0);
        check_value("spur_fillD_rdy", fillD_rdy, 1'b0);
        check_value("spur_busy", busy, 1'b0);
        check_value("spur_mem_req", mem_req, 1'b0);
        check_value("spur_fillI_data", fillI_data, exp_i);
        check_value("spur_fillD_data", fillD_data, exp_d);

        // Reset asserted between edges while BUSY.
        reqI_mem = 1'b1; reqAddrI_mem = 26'h55;
        @(negedge clk);
        check_value("mid_busy", busy, 1'b1);
        #2 reset = 1'b1;
        reqI_mem = 1'b0;
        #1;
        check_value("rstb_mem_req", mem_req, 1'b0);
        check_value("rstb_busy", busy, 1'b0);
        check_value("rstb_grant_id", grant_id, 1'b0);
        check_value("rstb_stat", stat_conflicts, 16'd0);
        check_value("rstb_mem_addr", mem_addr, 26'd0);
        check_value("rstb_fillI_data", fillI_data, 128'd0);
        check_value("rstb_fillD_data", fillD_data, 128'd0);
        exp_i = '0; exp_d = '0;
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check_value("late_ack_rdy", fillI_rdy, 1'b0);
        check_value("late_ack_data", fillI_data, 128'd0);
        single_txn(1'b0, 1'b0, 26'h3C, 128'd0, {4{32'h1234_5678}}, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks_total);
        $finish;
    end

endmodule
